svm_det_collector: RTL

- Consumer end of the SVM controller output: accepts one classified slide-window result per `i_valid` pulse (window index plus signed SVM score).
- Thresholds the score and converts the linear window index to (row, col) grid coordinates. Row and column are the window's position in the 39-column block grid.
- Queues detections in a small show-ahead FIFO that the downstream bbox/host interface drains with a valid/ready handshake.
- Reports end-of-frame with a per-frame detection count.

---
 rtl/svm_det_collector.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/svm_det_collector.sv
// svm_det_collector
// Consumer end of the SVM controller output. Each i_valid pulse carries one
// classified slide-window result (linear window index plus signed score).
// The result is thresholded, the index is split into (row, col) on the
// 39-column block grid, and detections are queued in a show-ahead FIFO that
// the downstream bbox/host logic drains with a valid/ready handshake. The
// last window of a frame produces a one-cycle frame-done pulse together with
// the number of detections that were accepted into the FIFO for that frame.
//
// Ports
//   clk, rst       clock; synchronous active-low reset
//   i_valid        one-cycle pulse qualifying i_sw_id / i_score
//   i_sw_id        slide-window index
//   i_score        signed SVM score
//   threshold      signed detection threshold (quasi-static)
//   o_det_valid    FIFO head valid (FIFO not empty)
//   o_det_ready    downstream consumes the head this cycle
//   o_det_row/col  grid position of the head entry
//   o_det_score    score of the head entry
//   o_frame_done   one-cycle pulse after the last window of a frame
//   o_det_count    detections accepted this frame, held until next frame end
//   o_overflow     sticky: a detection was dropped on a full FIFO
module svm_det_collector #(
    parameter int SW_W      = 11,
    parameter int SCORE_W   = 24,
    parameter int COL_N     = 39,
    parameter int MAX_SW_ID = 1130,
    parameter int DEPTH     = 8,
    parameter int RECIP     = 1681
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic [SW_W-1:0]           i_sw_id,
    input  logic signed [SCORE_W-1:0] i_score,
    input  logic signed [SCORE_W-1:0] threshold,
    output logic                      o_det_valid,
    input  logic                      o_det_ready,
    output logic [4:0]                o_det_row,
    output logic [5:0]                o_det_col,
    output logic signed [SCORE_W-1:0] o_det_score,
    output logic                      o_frame_done,
    output logic [SW_W-1:0]           o_det_count,
    output logic                      o_overflow
);

    localparam int PROD_W  = SW_W + 11;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 5 + 6 + SCORE_W;

    // ---------------- S1: capture and threshold ----------------
    logic                      s1_valid_q;
    logic                      s1_hit_q;
    logic [SW_W-1:0]           s1_id_q;
    logic signed [SCORE_W-1:0] s1_score_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_id_q    <= '0;
            s1_score_q <= '0;
        end else begin
            s1_valid_q <= i_valid;
            s1_hit_q   <= i_valid && (i_score > threshold);
            s1_id_q    <= i_sw_id;
            s1_score_q <= i_score;
        end
    end

    // ---------------- S2: row via reciprocal multiply ----------------
    // floor(id * 1681 / 2^16) equals floor(id / 39) for every index in range,
    // so no divider is needed.
    logic [PROD_W-1:0] s2_prod;
    logic [4:0]        s2_row_d;

    assign s2_prod  = PROD_W'(s1_id_q) * PROD_W'(RECIP);
    assign s2_row_d = s2_prod[16 +: 5];

    logic                      s2_valid_q;
    logic                      s2_hit_q;
    logic [SW_W-1:0]           s2_id_q;
    logic [4:0]                s2_row_q;
    logic signed [SCORE_W-1:0] s2_score_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_hit_q   <= 1'b0;
            s2_id_q    <= '0;
            s2_row_q   <= '0;
            s2_score_q <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_hit_q   <= s1_hit_q;
            s2_id_q    <= s1_id_q;
            s2_row_q   <= s2_row_d;
            s2_score_q <= s1_score_q;
        end
    end

    // ---------------- S3: column, FIFO push, frame end ----------------
    logic [SW_W-1:0]    s3_row_x_n;
    logic [SW_W-1:0]    s3_col_wide;
    logic [5:0]         s3_col;
    logic [ENTRY_W-1:0] s3_entry;

    assign s3_row_x_n  = SW_W'(s2_row_q) * SW_W'(COL_N);
    assign s3_col_wide = s2_id_q - s3_row_x_n;
    assign s3_col      = s3_col_wide[5:0];
    assign s3_entry    = {s2_row_q, s3_col, s2_score_q};

    // Bits of the intermediate products that are never needed.
    logic unused_bits;
    assign unused_bits = ^{s2_prod[15:0], s2_prod[PROD_W-1:21], s3_col_wide[SW_W-1:6]};

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               overflow_q;
    logic [SW_W-1:0]    frame_cnt_q;
    logic               frame_done_q;
    logic [SW_W-1:0]    det_count_q;

    logic fifo_full;
    logic pop;
    logic push_req;
    logic push_ok;
    logic drop;
    logic frame_end;

    assign fifo_full = (count_q == (PTR_W+1)'(DEPTH));
    assign pop       = (count_q != '0) && o_det_ready;
    assign push_req  = s2_valid_q && s2_hit_q;
    // A full FIFO still takes the new entry when the head leaves this cycle.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign drop      = push_req && fifo_full && !pop;
    assign frame_end = s2_valid_q && (s2_id_q == SW_W'(MAX_SW_ID));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            det_count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= s3_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase

            overflow_q   <= overflow_q | drop;
            frame_done_q <= frame_end;

            // The final window's own detection counts toward its frame.
            if (frame_end) begin
                det_count_q <= frame_cnt_q + SW_W'(push_ok);
                frame_cnt_q <= '0;
            end else begin
                frame_cnt_q <= frame_cnt_q + SW_W'(push_ok);
            end
        end
    end

    logic [ENTRY_W-1:0] head;
    assign head = mem_q[rd_ptr_q];

    assign o_det_valid  = (count_q != '0);
    assign o_det_row    = head[ENTRY_W-1 -: 5];
    assign o_det_col    = head[SCORE_W +: 6];
    assign o_det_score  = head[SCORE_W-1:0];
    assign o_frame_done = frame_done_q;
    assign o_det_count  = det_count_q;
    assign o_overflow   = overflow_q;

endmodule
